// File: rtl/addr_table_arbiter_if.sv
// Request/response bundle between the requesting datapath blocks and addr_table_arbiter.
// The master side drives requests. The slave side is the arbiter.
interface addr_table_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned DATA_W  = 4
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*IDX_W-1:0]  req_idx;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_rdata;
  logic [2*NUM_REQ-1:0]      status;
  logic                      flag;

  modport master (
    output req_valid, req_write, req_idx, req_wdata,
    input  req_ready, rsp_valid, rsp_id, rsp_rdata, status, flag
  );

  modport slave (
    input  req_valid, req_write, req_idx, req_wdata,
    output req_ready, rsp_valid, rsp_id, rsp_rdata, status, flag
  );
endinterface

// File: rtl/addr_table_arbiter.sv
// Round-robin arbiter and access sequencer for a shared DEPTH x DATA_W address table.
// It serves one read or write per 3-cycle IDLE/ACCESS/RESP pass, and every output is registered.
module addr_table_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned DATA_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  addr_table_arbiter_if.slave bus
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  localparam logic [1:0] ST_CODE_IDLE   = 2'b00;
  localparam logic [1:0] ST_CODE_PEND   = 2'b01;
  localparam logic [1:0] ST_CODE_ACTIVE = 2'b10;
  localparam logic [1:0] ST_CODE_ERROR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
  logic                wr_q, wr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NUM_REQ-1:0]  err_q, err_d;

  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic [2*NUM_REQ-1:0] status_q, status_d;
  logic                 flag_q, flag_d;

  logic [DATA_W-1:0] table_q [DEPTH];
  logic              tbl_we;
  logic              in_range;

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_sel;
  logic              sel_write;
  logic [IDX_W-1:0]  sel_idx;
  logic [DATA_W-1:0] sel_wdata;

  // First valid requester after the last winner, wrapping.
  always_comb begin : rr_pick
    int unsigned cand;
    gnt_found = 1'b0;
    gnt_sel   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!gnt_found && bus.req_valid[ID_W'(cand)]) begin
        gnt_found = 1'b1;
        gnt_sel   = ID_W'(cand);
      end
    end
  end

  // Fields of the selected requester.
  always_comb begin : sel_mux
    sel_write = 1'b0;
    sel_idx   = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_sel == ID_W'(i)) begin
        sel_write = bus.req_write[i];
        sel_idx   = bus.req_idx[i*IDX_W +: IDX_W];
        sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign in_range = (32'(idx_q) < DEPTH);

  // Next-state logic. The output values are computed from the state the FSM is entering.
  always_comb begin : fsm_next
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_id_d    = gnt_id_q;
    wr_d        = wr_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    err_d       = err_q;
    tbl_we      = 1'b0;
    ready_d     = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = '0;
    rsp_rdata_d = '0;
    status_d    = '0;
    flag_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          ready_d[gnt_sel] = 1'b1;
          gnt_id_d         = gnt_sel;
          wr_d             = sel_write;
          idx_d            = sel_idx;
          wdata_d          = sel_wdata;
          ptr_d            = gnt_sel;
          err_d[gnt_sel]   = 1'b0;
          state_d          = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (in_range) begin
          if (wr_q) begin
            tbl_we = 1'b1;
            data_d = wdata_q;
          end else begin
            data_d = table_q[idx_q];
          end
        end else begin
          data_d          = '0;
          err_d[gnt_id_q] = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = gnt_id_q;
        rsp_rdata_d = data_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    flag_d = (state_d != ST_IDLE);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (flag_d && gnt_id_d == ID_W'(i))   status_d[2*i +: 2] = ST_CODE_ACTIVE;
      else if (err_d[i])                    status_d[2*i +: 2] = ST_CODE_ERROR;
      else if (bus.req_valid[i])            status_d[2*i +: 2] = ST_CODE_PEND;
      else                                  status_d[2*i +: 2] = ST_CODE_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : fsm_reg
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      gnt_id_q    <= '0;
      wr_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
      err_q       <= '0;
      ready_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_rdata_q <= '0;
      status_q    <= '0;
      flag_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_id_q    <= gnt_id_d;
      wr_q        <= wr_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rdata_q <= rsp_rdata_d;
      status_q    <= status_d;
      flag_q      <= flag_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : table_reg
    if (!rst_n) begin
      for (int unsigned e = 0; e < DEPTH; e++) table_q[e] <= '0;
    end else if (tbl_we) begin
      table_q[idx_q] <= wdata_q;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.status    = status_q;
  assign bus.flag      = flag_q;
endmodule

// File: tb/tb_addr_table_arbiter.sv
// Directed bench for addr_table_arbiter with a cycle-level reference model and a per-cycle compare.
// A separate set of literal checks fixes the reference model to known expected values.
module tb_addr_table_arbiter;
  localparam int unsigned NR    = 4;
  localparam int unsigned DEPTH = 12;
  localparam int unsigned IW    = 4;
  localparam int unsigned DW    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  addr_table_arbiter_if #(.NUM_REQ(NR), .IDX_W(IW), .DATA_W(DW)) bus ();

  addr_table_arbiter #(.NUM_REQ(NR), .DEPTH(DEPTH), .IDX_W(IW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a phase count of 0/1/2 plus the table, with each transaction handled as a whole.
  int m_phase, m_ptr, m_cur, m_idx, m_wd, m_data;
  bit m_w;
  int m_table [DEPTH];
  bit m_err [NR];
  int e_ready, e_rsp_valid, e_rsp_id, e_rsp_rdata, e_status, e_flag;

  task automatic model_reset();
    m_phase = 0; m_ptr = NR - 1; m_cur = 0; m_idx = 0; m_wd = 0; m_data = 0; m_w = 0;
    for (int e = 0; e < DEPTH; e++) m_table[e] = 0;
    for (int i = 0; i < NR; i++) m_err[i] = 0;
    e_ready = 0; e_rsp_valid = 0; e_rsp_id = 0; e_rsp_rdata = 0; e_status = 0; e_flag = 0;
  endtask

  task automatic model_step();
    int g;
    int j;
    int code;
    e_ready = 0; e_rsp_valid = 0; e_rsp_id = 0; e_rsp_rdata = 0;
    if (m_phase == 0) begin
      g = -1;
      for (int k = 1; k <= NR; k++) begin
        j = (m_ptr + k) % NR;
        if (g < 0 && bus.req_valid[j]) g = j;
      end
      if (g >= 0) begin
        e_ready  = 1 << g;
        m_cur    = g;
        m_w      = bus.req_write[g];
        m_idx    = int'(bus.req_idx[g*IW +: IW]);
        m_wd     = int'(bus.req_wdata[g*DW +: DW]);
        m_ptr    = g;
        m_err[g] = 0;
        m_phase  = 1;
      end
    end else if (m_phase == 1) begin
      if (m_idx < DEPTH) begin
        if (m_w) begin
          m_table[m_idx] = m_wd;
          m_data = m_wd;
        end else begin
          m_data = m_table[m_idx];
        end
      end else begin
        m_data = 0;
        m_err[m_cur] = 1;
      end
      m_phase = 2;
    end else begin
      e_rsp_valid = 1; e_rsp_id = m_cur; e_rsp_rdata = m_data;
      m_phase = 0;
    end
    e_flag = (m_phase != 0) ? 1 : 0;
    e_status = 0;
    for (int i = 0; i < NR; i++) begin
      if (m_phase != 0 && i == m_cur) code = 2;
      else if (m_err[i])              code = 3;
      else if (bus.req_valid[i])      code = 1;
      else                            code = 0;
      e_status = e_status | (code << (2*i));
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Compare the DUT outputs with the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_ready",     32'(bus.req_ready), 32'(e_ready));
      check("cyc_rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp_valid));
      check("cyc_rsp_id",    32'(bus.rsp_id),    32'(e_rsp_id));
      check("cyc_rsp_rdata", 32'(bus.rsp_rdata), 32'(e_rsp_rdata));
      check("cyc_status",    32'(bus.status),    32'(e_status));
      check("cyc_flag",      32'(bus.flag),      32'(e_flag));
    end
  end

  // Stimulus side.
  bit [NR-1:0] drop_on_ready;
  logic [NR-1:0]   obs_ready;
  logic            obs_rsp_valid;
  logic [1:0]      obs_rsp_id;
  logic [DW-1:0]   obs_rsp_rdata;
  logic [2*NR-1:0] obs_status;
  logic [2*NR-1:0] st_at_ready;

  function automatic int onehot_id(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic run_cycle();
    @(posedge clk);
    #1;
    obs_ready     = bus.req_ready;
    obs_rsp_valid = bus.rsp_valid;
    obs_rsp_id    = bus.rsp_id;
    obs_rsp_rdata = bus.rsp_rdata;
    obs_status    = bus.status;
    for (int i = 0; i < NR; i++)
      if (drop_on_ready[i] && obs_ready[i]) bus.req_valid[i] = 1'b0;
  endtask

  task automatic set_req(input int i, input bit w, input int idx, input int wd);
    bus.req_write[i]            = w;
    bus.req_idx[i*IW +: IW]     = IW'(idx);
    bus.req_wdata[i*DW +: DW]   = DW'(wd);
    bus.req_valid[i]            = 1'b1;
    drop_on_ready[i]            = 1'b1;
  endtask

  // Issue one transaction and wait, up to a fixed cycle budget, for its response.
  task automatic do_txn(input string name, input int i, input bit w, input int idx,
                        input int wd, input int exp_data);
    bit done;
    done = 0;
    set_req(i, w, idx, wd);
    for (int k = 0; k < 20 && !done; k++) begin
      run_cycle();
      if (obs_ready[i]) st_at_ready = obs_status;
      if (obs_rsp_valid) begin
        done = 1;
        check({name, "_id"},   32'(obs_rsp_id),    32'(i));
        check({name, "_data"}, 32'(obs_rsp_rdata), 32'(exp_data));
      end
    end
    if (!done) check({name, "_timeout"}, 0, 1);
  endtask

  int rdy_cyc [4];
  int rdy_id  [4];
  int rsp_cyc [4];
  int rsp_id  [4];
  int rc, rs, cnt;
  int gseq [6];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0; bus.req_write = '0; bus.req_idx = '0; bus.req_wdata = '0;
    drop_on_ready = '0; st_at_ready = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_ready",  32'(bus.req_ready), 0);
    check("rst_status", 32'(bus.status),    0);
    check("rst_flag",   32'(bus.flag),      0);

    // Test 1: all four requesters read at the same time and are served in order 0..3.
    for (int i = 0; i < 4; i++) begin
      set_req(i, 1'b0, i, 0);
      rdy_cyc[i] = 99; rdy_id[i] = 99; rsp_cyc[i] = 99; rsp_id[i] = 99;
    end
    rc = 0; rs = 0;
    for (int k = 1; k <= 13; k++) begin
      run_cycle();
      if (obs_ready != '0 && rc < 4) begin
        rdy_cyc[rc] = k; rdy_id[rc] = onehot_id(obs_ready); rc++;
      end
      if (obs_rsp_valid && rs < 4) begin
        rsp_cyc[rs] = k; rsp_id[rs] = int'(obs_rsp_id); rs++;
      end
    end
    for (int j = 0; j < 4; j++) begin
      check($sformatf("t1_ready_cyc%0d", j), 32'(rdy_cyc[j]), 32'(1 + 3*j));
      check($sformatf("t1_ready_id%0d", j),  32'(rdy_id[j]),  32'(j));
      check($sformatf("t1_rsp_cyc%0d", j),   32'(rsp_cyc[j]), 32'(3 + 3*j));
      check($sformatf("t1_rsp_id%0d", j),    32'(rsp_id[j]),  32'(j));
    end

    // Test 2: a read that follows a write to the same index returns the written value.
    do_txn("t2_wr",   2, 1'b1, 5, 'hA, 'hA);
    do_txn("t2_rd5",  0, 1'b0, 5, 0,   'hA);
    do_txn("t2_rd4",  0, 1'b0, 4, 0,   0);

    // Test 3: an out-of-range write returns 0 and sets a sticky error, which the next accept clears.
    do_txn("t3_oor",  1, 1'b1, 13, 7, 0);
    check("t3_status_err", 32'(obs_status[3:2]), 3);
    do_txn("t3_rd0",  1, 1'b0, 0, 0, 0);
    check("t3_status_active", 32'(st_at_ready[3:2]), 2);
    do_txn("t3_rd1",  2, 1'b0, 1, 0, 0);

    // Test 4: reset asserted while the FSM is in ACCESS for a write.
    set_req(3, 1'b1, 7, 'hC);
    cnt = 0;
    for (int k = 0; k < 10 && cnt == 0; k++) begin
      run_cycle();
      if (obs_ready[3]) cnt = 1;
    end
    check("t4_granted", 32'(cnt), 1);
    rst_n = 1'b0;
    bus.req_valid = '0;
    #1;
    check("t4_rst_ready",  32'(bus.req_ready), 0);
    check("t4_rst_rspv",   32'(bus.rsp_valid), 0);
    check("t4_rst_flag",   32'(bus.flag),      0);
    check("t4_rst_status", 32'(bus.status),    0);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      run_cycle();
      if (obs_rsp_valid) cnt++;
    end
    check("t4_no_rsp", 32'(cnt), 0);
    rst_n = 1'b1;
    do_txn("t4_rd5", 0, 1'b0, 5, 0, 0);
    do_txn("t4_rd7", 3, 1'b0, 7, 0, 0);

    // Test 5: two requesters holding valid are granted alternately.
    set_req(0, 1'b0, 2, 0);
    set_req(3, 1'b0, 3, 0);
    drop_on_ready[0] = 1'b0;
    drop_on_ready[3] = 1'b0;
    for (int j = 0; j < 6; j++) gseq[j] = 99;
    rc = 0;
    for (int k = 0; k < 20; k++) begin
      run_cycle();
      if (obs_ready != '0 && rc < 6) begin
        gseq[rc] = onehot_id(obs_ready); rc++;
      end
    end
    for (int j = 0; j < 6; j++)
      check($sformatf("t5_grant%0d", j), 32'(gseq[j]), (j % 2 == 0) ? 0 : 3);
    bus.req_valid = '0;
    drop_on_ready = '1;
    repeat (4) run_cycle();

    // Test 6: a request withdrawn during another transaction is never granted.
    set_req(2, 1'b0, 0, 0);
    run_cycle();
    check("t6_ready2", 32'(obs_ready), 32'(4));
    bus.req_write[1] = 1'b0;
    bus.req_valid[1] = 1'b1;
    run_cycle();
    check("t6_pend_a", 32'(obs_status[3:2]), 1);
    run_cycle();
    check("t6_pend_b", 32'(obs_status[3:2]), 1);
    bus.req_valid[1] = 1'b0;
    run_cycle();
    check("t6_idle", 32'(obs_status[3:2]), 0);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      run_cycle();
      if (obs_ready[1]) cnt++;
    end
    check("t6_never_granted", 32'(cnt), 0);

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
